// File: rtl/seg_pkg.sv
// Shared constants, types and the active-low 7-segment font for seg_display_scan.
package seg_pkg;

  localparam int         N_DIGITS = 4;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_OFF   = 4'hF;

  // Cathode bit order on seg_cat: bit 6 = g ... bit 0 = a
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_cat_t;

  typedef enum logic {
    CONV_IDLE = 1'b0,
    CONV_RUN  = 1'b1
  } conv_state_t;

  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// Write port of seg_display_scan: one display word plus per-digit blanking, valid/ready.
interface seg_display_scan_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_value;
  logic [3:0]  wr_blank;

  modport master (output wr_valid, output wr_value, output wr_blank, input wr_ready);
  modport slave  (input wr_valid, input wr_value, input wr_blank, output wr_ready);
endinterface

// File: rtl/seg_bin2bcd.sv
// Iterative 14-bit binary to 4-digit BCD converter, one double-dabble step per cycle.
// state     | meaning
// CONV_IDLE | waiting for start; operand captured on start
// CONV_RUN  | one shift/add-3 step per cycle; done pulses on the 14th step
import seg_pkg::*;

module seg_bin2bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        over
);

  localparam int          N_BITS  = 14;
  localparam logic [13:0] BCD_MAX = 14'd9999;

  conv_state_t state, state_nx;
  logic [13:0] bin_sr, bin_nx;
  logic [15:0] bcd_sr, bcd_nx, bcd_adj;
  logic [3:0]  cnt, cnt_nx;
  logic        over_q, over_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= CONV_IDLE;
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
      over_q <= 1'b0;
    end else begin
      state  <= state_nx;
      bin_sr <= bin_nx;
      bcd_sr <= bcd_nx;
      cnt    <= cnt_nx;
      over_q <= over_nx;
    end
  end

  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
    end
    // bcd carries the result of the step in progress; valid to the consumer only with done
    bcd      = {bcd_adj[14:0], bin_sr[13]};
    state_nx = state;
    bin_nx   = bin_sr;
    bcd_nx   = bcd_sr;
    cnt_nx   = cnt;
    over_nx  = over_q;
    done     = 1'b0;
    case (state)
      CONV_IDLE: begin
        if (start) begin
          state_nx = CONV_RUN;
          bin_nx   = bin;
          bcd_nx   = '0;
          cnt_nx   = '0;
          over_nx  = (bin > BCD_MAX);
        end
      end
      CONV_RUN: begin
        bcd_nx = bcd;
        bin_nx = {bin_sr[12:0], 1'b0};
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'(N_BITS - 1)) begin
          done     = 1'b1;
          state_nx = CONV_IDLE;
        end
      end
      default: state_nx = CONV_IDLE;
    endcase
  end

  assign busy = (state == CONV_RUN);
  assign over = over_q;

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed 4-digit 7-segment scanner with frame-aligned double buffering.
// Define SEG_BCD_EN to treat wr_value[13:0] as binary and convert it to decimal digits.
import seg_pkg::*;

module seg_display_scan #(
  parameter int CLK_FREQ     = 100000000,
  parameter int REFRESH_HZ   = 1000,
  parameter int GHOST_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  seg_display_scan_if.slave   wr,
  output logic [6:0]          seg_cat,
  output logic [3:0]          seg_anode,
  output logic                frame_start
);

  // TICK_DIV must be at least GHOST_CYCLES+2 so every slot has visible time
  localparam int TICK_DIV = CLK_FREQ / (REFRESH_HZ * N_DIGITS);
  localparam int PW       = $clog2(TICK_DIV);

  logic [PW-1:0] prescaler;
  logic [1:0]    index;
  logic          tick, frame_end;

  logic          pending;
  logic [15:0]   pend_value, act_value;
  logic [3:0]    pend_blank, act_blank;
  logic          pend_dash, act_dash;

  logic          accept, busy, load, load_dash;
  logic [15:0]   load_value;
  logic [3:0]    load_blank;

  assign tick        = (prescaler == PW'(TICK_DIV - 1));
  assign frame_end   = tick && (index == 2'(N_DIGITS - 1));
  assign wr.wr_ready = !pending && !busy;
  assign accept      = wr.wr_valid && wr.wr_ready;

`ifdef SEG_BCD_EN
  logic        conv_done, conv_over;
  logic [15:0] conv_bcd;
  logic [3:0]  blank_hold;

  seg_bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .bin   (wr.wr_value[13:0]),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .over  (conv_over)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        blank_hold <= AN_OFF;
    else if (accept) blank_hold <= wr.wr_blank;
  end

  assign load       = conv_done;
  assign load_value = conv_bcd;
  assign load_blank = blank_hold;
  assign load_dash  = conv_over;
`else
  assign busy       = 1'b0;
  assign load       = accept;
  assign load_value = wr.wr_value;
  assign load_blank = wr.wr_blank;
  assign load_dash  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      index     <= '0;
    end else if (tick) begin
      prescaler <= '0;
      index     <= frame_end ? 2'd0 : index + 2'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // A load can never coincide with a swap: load needs pending clear, swap needs it set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= 1'b0;
      pend_value <= '0;
      pend_blank <= AN_OFF;
      pend_dash  <= 1'b0;
      act_value  <= '0;
      act_blank  <= AN_OFF;
      act_dash   <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        act_value <= pend_value;
        act_blank <= pend_blank;
        act_dash  <= pend_dash;
        pending   <= 1'b0;
      end
      if (load) begin
        pend_value <= load_value;
        pend_blank <= load_blank;
        pend_dash  <= load_dash;
        pending    <= 1'b1;
      end
    end
  end

  logic [3:0] cur_nib;
  logic       cur_blank;

  assign cur_nib   = act_value[index*4 +: 4];
  assign cur_blank = act_blank[index];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_anode   <= AN_OFF;
      seg_cat     <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      seg_anode   <= (prescaler < PW'(GHOST_CYCLES) || cur_blank) ? AN_OFF
                     : ~(4'b0001 << index);
      seg_cat     <= cur_blank ? SEG_OFF : (act_dash ? SEG_DASH : seg_font(cur_nib));
      frame_start <= frame_end;
    end
  end

endmodule
